// File: rtl/player2_link_rx.sv
// player2_link_rx: synchronizes, deglitches and validates the six peer player-2 link lines.
//   Parameter: STABLE_CYCLES - identical samples needed before a new word commits (2..2^20).
//   Optional feature macro: PLAYER_LINK_ERR_CHECK_EN enables the score monotonicity checker.
//   Inputs : clk, rst (sync, active-high), player2_pause_raw, player2_reload_raw,
//            player2_score_raw[3:0] (all async), err_clr (sync, clears score_error).
//   Outputs: player2_pause (level), player2_reload (pulse on committed 0->1),
//            player2_score[3:0] (level), score_update (pulse on committed change),
//            score_error (sticky score fault).
module player2_link_rx #(
    parameter int STABLE_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       player2_pause_raw,
    input  logic       player2_reload_raw,
    input  logic [3:0] player2_score_raw,
    input  logic       err_clr,
    output logic       player2_pause,
    output logic       player2_reload,
    output logic [3:0] player2_score,
    output logic       score_update,
    output logic       score_error
);
    localparam int CW = $clog2(STABLE_CYCLES);

    typedef enum logic {STABLE, SETTLE} state_t;

    state_t        state, state_n;
    logic [5:0]    sync_a, sync_w;
    logic [5:0]    cand, cand_n, comm, comm_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          commit, reload_q, update_q;

    // word layout: {pause, reload, score[3:0]}
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a   <= '0;
            sync_w   <= '0;
            state    <= STABLE;
            cand     <= '0;
            cnt      <= '0;
            comm     <= '0;
            reload_q <= 1'b0;
            update_q <= 1'b0;
        end else begin
            sync_a   <= {player2_pause_raw, player2_reload_raw, player2_score_raw};
            sync_w   <= sync_a;
            state    <= state_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            comm     <= comm_n;
            reload_q <= commit & cand[4] & ~comm[4];
            update_q <= commit & (cand[3:0] != comm[3:0]);
        end
    end

    // any change of the synchronized word during SETTLE restarts the count,
    // so skewed multi-bit transitions only commit their final coherent value
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        comm_n  = comm;
        commit  = 1'b0;
        if (state == STABLE) begin
            if (sync_w != comm) begin
                cand_n  = sync_w;
                cnt_n   = '0;
                state_n = SETTLE;
            end
        end else if (sync_w != cand) begin
            cand_n = sync_w;
            cnt_n  = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            commit  = 1'b1;
            comm_n  = cand;
            state_n = STABLE;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

`ifdef PLAYER_LINK_ERR_CHECK_EN
    logic err_q;

    // a decrease to a nonzero score is a fault; dropping to zero is a legal reset
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (commit && cand[3:0] < comm[3:0] && cand[3:0] != 4'd0)
            err_q <= 1'b1;
        else if (err_clr)
            err_q <= 1'b0;
    end

    assign score_error = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign score_error    = 1'b0;
`endif

    assign player2_pause  = comm[5];
    assign player2_score  = comm[3:0];
    assign player2_reload = reload_q;
    assign score_update   = update_q;
endmodule

// File: tb/tb_player2_link_rx.sv
// tb_player2_link_rx: directed self-checking bench for player2_link_rx with STABLE_CYCLES=4.
module tb_player2_link_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_raw = 1'b0;
    logic       reload_raw = 1'b0;
    logic [3:0] score_raw = 4'h0;
    logic       err_clr = 1'b0;
    logic       player2_pause, player2_reload, score_update, score_error;
    logic [3:0] player2_score;

    int tests = 0;
    int fails = 0;
    int n_rel = 0;
    int n_upd = 0;

`ifdef PLAYER_LINK_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    player2_link_rx #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .player2_pause_raw(pause_raw),
        .player2_reload_raw(reload_raw),
        .player2_score_raw(score_raw),
        .err_clr(err_clr),
        .player2_pause(player2_pause),
        .player2_reload(player2_reload),
        .player2_score(player2_score),
        .score_update(score_update),
        .score_error(score_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (player2_reload) n_rel++;
        if (score_update) n_upd++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; pause_raw = 1'b1; reload_raw = 1'b1; score_raw = 4'hF;
        step();
        tests++;
        if ({player2_pause, player2_reload, player2_score, score_update, score_error} !== 8'h00) begin
            fails++;
            $display("FAIL reset_during: got %b want 00000000",
                     {player2_pause, player2_reload, player2_score, score_update, score_error});
        end
        rst = 1'b0;
        step(6);
        tests++;
        if ({player2_pause, player2_reload, player2_score, score_update} !== 7'h00) begin
            fails++;
            $display("FAIL reset_edge5: got %b want 0000000",
                     {player2_pause, player2_reload, player2_score, score_update});
        end
        step();
        tests++;
        if ({player2_pause, player2_reload, player2_score, score_update, score_error} !== 8'b1_1_1111_1_0) begin
            fails++;
            $display("FAIL reset_edge6: got %b want 11111110",
                     {player2_pause, player2_reload, player2_score, score_update, score_error});
        end
        step();
        tests++;
        if ({player2_reload, score_update} !== 2'b00) begin
            fails++;
            $display("FAIL reset_edge7_pulses: got %b want 00", {player2_reload, score_update});
        end
    endtask

    task automatic test_glitch;
        int r0;
        pause_raw = 1'b0; reload_raw = 1'b0; score_raw = 4'h0;
        step(12);
        r0 = n_rel;
        reload_raw = 1'b1;
        step(3);
        reload_raw = 1'b0;
        step(20);
        tests++;
        if (n_rel - r0 !== 0) begin
            fails++;
            $display("FAIL glitch_pulses: got %0d want 0", n_rel - r0);
        end
        tests++;
        if ({player2_pause, player2_score} !== 5'h00) begin
            fails++;
            $display("FAIL glitch_comm: got %h want 00", {player2_pause, player2_score});
        end
        reload_raw = 1'b1;
        step(6);
        tests++;
        if (player2_reload !== 1'b0) begin
            fails++;
            $display("FAIL reload_edge5: got %b want 0", player2_reload);
        end
        step();
        tests++;
        if (player2_reload !== 1'b1) begin
            fails++;
            $display("FAIL reload_edge6: got %b want 1", player2_reload);
        end
        step();
        tests++;
        if (player2_reload !== 1'b0) begin
            fails++;
            $display("FAIL reload_edge7: got %b want 0", player2_reload);
        end
        step(12);
        tests++;
        if (n_rel - r0 !== 1) begin
            fails++;
            $display("FAIL reload_count: got %0d want 1", n_rel - r0);
        end
        reload_raw = 1'b0;
        step(12);
    endtask

    task automatic test_skew;
        int  u0;
        bit  bad = 0;
        score_raw = 4'h3;
        step(12);
        u0 = n_upd;
        score_raw = 4'h7;
        step();
        score_raw = 4'h6;
        step();
        score_raw = 4'h4;
        for (int i = 0; i < 20; i++) begin
            step();
            if (player2_score !== 4'h3 && player2_score !== 4'h4) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL skew_intermediate: got bad=1 want 0");
        end
        tests++;
        if (player2_score !== 4'h4) begin
            fails++;
            $display("FAIL skew_final: got %h want 4", player2_score);
        end
        tests++;
        if (n_upd - u0 !== 1) begin
            fails++;
            $display("FAIL skew_updates: got %0d want 1", n_upd - u0);
        end
    endtask

    task automatic test_back_forth;
        int u0;
        bit bad = 0;
        score_raw = 4'h5;
        step(12);
        u0 = n_upd;
        score_raw = 4'h6;
        step(2);
        score_raw = 4'h5;
        for (int i = 0; i < 20; i++) begin
            step();
            if (player2_score !== 4'h5) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL backforth_score: got bad=1 want 0");
        end
        tests++;
        if (n_upd - u0 !== 0) begin
            fails++;
            $display("FAIL backforth_updates: got %0d want 0", n_upd - u0);
        end
    endtask

    task automatic test_checker;
        score_raw = 4'h9;
        step(12);
        tests++;
        if (score_error !== 1'b0) begin
            fails++;
            $display("FAIL chk_up_noerr: got %b want 0", score_error);
        end
        score_raw = 4'h7;
        step(6);
        tests++;
        if (score_error !== 1'b0) begin
            fails++;
            $display("FAIL chk_pre_commit: got %b want 0", score_error);
        end
        step();
        tests++;
        if (score_error !== ERR_EXP) begin
            fails++;
            $display("FAIL chk_9to7: got %b want %b", score_error, ERR_EXP);
        end
        step(6);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests++;
        if (score_error !== 1'b0) begin
            fails++;
            $display("FAIL chk_clear: got %b want 0", score_error);
        end
        score_raw = 4'h0;
        step(12);
        tests++;
        if (score_error !== 1'b0 || player2_score !== 4'h0) begin
            fails++;
            $display("FAIL chk_7to0: got err=%b score=%h want err=0 score=0", score_error, player2_score);
        end
        score_raw = 4'h8;
        step(12);
        score_raw = 4'h2;
        step(6);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests++;
        if (score_error !== ERR_EXP || player2_score !== 4'h2) begin
            fails++;
            $display("FAIL chk_set_wins: got err=%b score=%h want err=%b score=2",
                     score_error, player2_score, ERR_EXP);
        end
        step(4);
    endtask

    task automatic test_mid_reset;
        score_raw = 4'h6;
        step(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({player2_pause, player2_reload, player2_score, score_update, score_error} !== 8'h00) begin
            fails++;
            $display("FAIL midrst_outputs: got %b want 00000000",
                     {player2_pause, player2_reload, player2_score, score_update, score_error});
        end
        step(6);
        tests++;
        if (player2_score !== 4'h0 || score_update !== 1'b0) begin
            fails++;
            $display("FAIL midrst_edge5: got score=%h upd=%b want score=0 upd=0", player2_score, score_update);
        end
        step();
        tests++;
        if (player2_score !== 4'h6 || score_update !== 1'b1) begin
            fails++;
            $display("FAIL midrst_edge6: got score=%h upd=%b want score=6 upd=1", player2_score, score_update);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_skew();
        test_back_forth();
        test_checker();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
